lane_rr_sched: RTL and testbench
================================

Name: lane_rr_sched

Overview:
- Round-robin scheduler that shares one resource (a single-owner lane service) among W generated lane instances.
- Sits beside the parameterised lane array. Each lane raises a request, one lane at a time receives a one-hot grant, and the grant is held until the resource signals completion or the owner withdraws.
- Fairness is strict rotation starting after the last winner.

Parameters:
- W, 6, number of requesting lanes (W >= 1).
- HOLD_MAX, 15, maximum grant hold cycles before forced release (used only with the optional feature).
- IDW, $clog2(W) (min 1), width of gnt_id; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  W  per-lane request; level, sampled each clk.
- done  input  1  resource finished current owner's job; single-cycle pulse; meaningful only in GRANT.
- gnt  output  W  one-hot grant to owning lane, all-zero when no owner.
- gnt_id  output  IDW  binary index of owner; 0 when no owner.
- busy  output  1  high while a grant is held (equals |gnt).
- timeout  output  1  one-cycle pulse on forced release (optional feature only).

Behaviour:
- All outputs are registered.
- Reset (rst=1 at posedge) forces the following, regardless of state (mid-grant included):
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, rotation pointer ptr=0, hold counter=0.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Else select the first set bit scanning ptr, ptr+1, ..., W-1, 0, ..., ptr-1 (modulo W).
  - At the next posedge: gnt=onehot(winner), gnt_id=winner, busy=1, state=GRANT.
  - Latency: req seen high at edge n produces gnt high after edge n.
- GRANT:
  - Release on done=1 or req[gnt_id]=0.
  - At the next posedge after a release: gnt=0, gnt_id=0, busy=0, ptr=(gnt_id+1) wrapping W-1 to 0, state=IDLE.
  - Otherwise hold; requests from other lanes are ignored while in GRANT.
- Simultaneous events:
  - done=1 together with owner req drop is a single release; ptr advances once.
  - done asserted in IDLE is ignored.
- Back-to-back: at least one IDLE cycle occurs between consecutive grants (gnt=0 for >=1 cycle), even when the same lane re-requests.
- Wrap-around: ptr is updated only on release, never on reset-less idle.
- Degenerate cases:
  - W=1: gnt_id is 1 bit and stays 0; the block behaves as a simple grant/hold gate.
  - Bits of req beyond the lane count do not exist; no out-of-range gnt_id is ever produced.
- Invariants (assert in bench):
  - $onehot0(gnt).
  - busy==|gnt.
  - gnt[gnt_id]==busy.

Optional Feature:
- Macro: LANE_RR_SCHED_TIMEOUT_EN.
- Defined:
  - A hold counter (width $clog2(HOLD_MAX+1)) clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals HOLD_MAX and no done/req-drop occurs that cycle, the block performs a normal release at the next edge (ptr advances past the owner) and pulses timeout=1 for exactly that one cycle alongside gnt going 0.
  - A normal release in the same cycle takes priority (timeout stays 0).
- Undefined: no counter is instantiated, timeout is tied 0, and a grant is held indefinitely.

Test Plan:
- Reset/idle:
  - Stimulus: rst for 2 cycles with req=6'b111111, then rst=0.
  - Response: gnt=0 during reset; first grant gnt=6'b000001, gnt_id=0, one cycle after release of reset.
- Rotation:
  - Stimulus: req=6'b111111 held, done pulsed 3 cycles after each grant.
  - Response: grant sequence ids 0,1,2,3,4,5,0 with one gnt=0 cycle between each.
- Skip/wrap:
  - Stimulus: ptr at 5 (after id 4 released), req=6'b100100.
  - Response: grant id 5, then after done, id 2.
- Withdraw:
  - Stimulus: lane 3 granted, then req[3] dropped with done=0.
  - Response: gnt=0 next cycle; next winner is searched from id 4.
- Reset mid-grant:
  - Stimulus: lane 2 granted, rst=1 for one cycle.
  - Response: gnt=0, busy=0 after that edge; with req=6'b111111 the next grant is id 0 (ptr reset).
- Timeout (macro defined, HOLD_MAX=15):
  - Stimulus: lane 1 granted, done never asserted, req[1] held.
  - Response: 16th GRANT cycle is followed by gnt=0 with timeout=1 for one cycle; next grant goes to id 2 if requested.
  - Macro undefined: grant persists for more than 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/lane_rr_sched.sv
// rtl/lane_rr_sched.sv - round-robin single-owner grant scheduler for W lanes
//
// Ports:
//   clk     in   1    rising-edge clock
//   rst     in   1    synchronous reset, active-high
//   req     in   W    per-lane request level
//   done    in   1    owner's job finished (pulse, only meaningful while granted)
//   gnt     out  W    one-hot grant, zero when no owner
//   gnt_id  out  IDW  binary index of owner, zero when no owner
//   busy    out  1    grant held (equals |gnt)
//   timeout out  1    one-cycle pulse on forced release
//
// Optional feature: define LANE_RR_SCHED_TIMEOUT_EN to force a release after
// the owner has held the grant for HOLD_MAX+1 cycles. Without it timeout is
// tied low and a grant is held until done or request withdrawal.

module lane_rr_sched #(
    parameter int  W        = 6,
    parameter int  HOLD_MAX = 15,
    localparam int IDW      = (W > 1) ? $clog2(W) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   req,
    input  logic           done,
    output logic [W-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   gnt_n;
    logic [IDW-1:0] gnt_id_n;
    logic           busy_n;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_n;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;
    logic           owner_req;
    logic           normal_rel;
    logic           force_rel;

    // Rotate the request vector so the pointer lane sits at bit 0, take the
    // lowest set bit, then map the offset back to an absolute lane index.
    function automatic logic [IDW-1:0] rr_pick(input logic [W-1:0]   r,
                                               input logic [IDW-1:0] p);
        logic [W-1:0] rot;
        int           off;
        int           sum;
        rot = W'({r, r} >> p);
        off = 0;
        for (int k = W - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k;
            end
        end
        sum = int'(p) + off;
        if (sum >= W) begin
            sum = sum - W;
        end
        return IDW'(sum);
    endfunction

    assign winner     = rr_pick(req, ptr);
    assign owner_req  = |(req & gnt);
    assign normal_rel = done || !owner_req;
    assign next_ptr   = (gnt_id == IDW'(W - 1)) ? '0 : gnt_id + IDW'(1);

`ifdef LANE_RR_SCHED_TIMEOUT_EN
    localparam int HCW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_cnt_n;
    logic           timeout_n;

    assign force_rel = (state == GRANT) && (hold_cnt == HCW'(HOLD_MAX));

    // Counter is zero on the first GRANT cycle and counts every cycle held.
    always_comb begin
        hold_cnt_n = '0;
        timeout_n  = 1'b0;
        if (state == GRANT) begin
            if (normal_rel) begin
                hold_cnt_n = '0;
            end else if (force_rel) begin
                hold_cnt_n = '0;
                timeout_n  = 1'b1;
            end else begin
                hold_cnt_n = hold_cnt + HCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_n;
            timeout  <= timeout_n;
        end
    end
`else
    logic unused_hold_max;

    assign unused_hold_max = |HOLD_MAX;
    assign force_rel       = 1'b0;
    assign timeout         = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        busy_n   = busy;
        ptr_n    = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n  = GRANT;
                    gnt_n    = W'(1) << winner;
                    gnt_id_n = winner;
                    busy_n   = 1'b1;
                end
            end
            GRANT: begin
                // Other lanes' requests are ignored; only the owner matters.
                if (normal_rel || force_rel) begin
                    state_n  = IDLE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    ptr_n    = next_ptr;
                end
            end
            default: begin
                state_n  = IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            gnt_id <= gnt_id_n;
            busy   <= busy_n;
            ptr    <= ptr_n;
        end
    end

endmodule

// File: tb/tb_lane_rr_sched.sv
// tb/tb_lane_rr_sched.sv - self-checking bench for lane_rr_sched

module tb_lane_rr_sched;

    localparam int W        = 6;
    localparam int HOLD_MAX = 15;
    localparam int IDW      = 3;
`ifdef LANE_RR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   req;
    logic           done;
    logic [W-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: owner lane (-1 = none), rotation pointer, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    lane_rr_sched #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rel;
        bit frc;
        bit found;
        int c;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 0; k < W; k++) begin
                c = (m_ptr + k) % W;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_hold  = 0;
                end
            end
        end else begin
            rel = done || !req[m_owner];
            frc = TO_EN && (m_hold == HOLD_MAX);
            if (rel || frc) begin
                m_to    = frc && !rel;
                m_ptr   = (m_owner + 1) % W;
                m_owner = -1;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] exp_gnt;
        if (chk_en) begin
            exp_gnt = (m_owner < 0) ? '0 : (W'(1) << m_owner);
            check("gnt", gnt, exp_gnt);
            check("gnt_id", gnt_id, (m_owner < 0) ? 0 : m_owner);
            check("busy", busy, m_owner >= 0);
            check("timeout", timeout, m_to);
            check("inv_onehot0", $onehot0(gnt), 1);
            check("inv_busy_or", busy, |gnt);
            check("inv_gnt_at_id", gnt[gnt_id], busy);
        end
    end

    task automatic wait_grant(input int exp_id);
        int n;
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_seen", busy, 1);
        check("grant_id", gnt_id, exp_id);
    endtask

    task automatic done_release();
        repeat (2) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("release_gap", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        bit to_seen;
        rst  = 1'b1;
        req  = '1;
        done = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_gnt", gnt, 0);
        @(negedge clk);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("first_gnt", gnt, 6'b000001);
        check("first_id", gnt_id, 0);
        done_release();

        for (int k = 1; k <= 6; k++) begin
            wait_grant(k % 6);
            done_release();
        end

        req = 6'b010000;
        wait_grant(4);
        done_release();
        req = 6'b100100;
        wait_grant(5);
        done_release();
        wait_grant(2);
        done_release();

        req = 6'b001000;
        wait_grant(3);
        @(negedge clk);
        req = 6'b100100;
        @(negedge clk);
        check("withdraw_rel", busy, 0);
        wait_grant(5);

        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(negedge clk);
        done = 1'b0;
        check("dual_rel", busy, 0);
        req = '1;
        wait_grant(0);

        req = 6'b000001;
        done_release();
        wait_grant(0);
        done_release();
        req = '0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("idle_done", busy, 0);

        req = 6'b000100;
        wait_grant(2);
        @(negedge clk);
        rst = 1'b1;
        req = '1;
        @(negedge clk);
        check("midrst_gnt", gnt, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        wait_grant(0);
        done_release();

        req = 6'b000010;
        wait_grant(1);
`ifdef LANE_RR_SCHED_TIMEOUT_EN
        held = 1;
        while (busy && held < 40) begin
            @(negedge clk);
            if (busy) held++;
        end
        check("to_hold_cycles", held, 16);
        check("to_pulse", timeout, 1);
        req = 6'b000110;
        @(negedge clk);
        check("to_pulse_end", timeout, 0);
        wait_grant(2);
        req = '0;
`else
        held    = 0;
        to_seen = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (busy) held++;
            if (timeout) to_seen = 1'b1;
        end
        check("hold_forever", held, 120);
        check("no_timeout", to_seen, 0);
        req = '0;
`endif
        repeat (3) @(negedge clk);
        check("final_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
